// File: rtl/xrv_issue_ctrl_pkg.sv
// Shared definitions for the issue controller slice.
//  - RV32 major opcodes consulted by the load-use hazard check
//  - issue FSM state encoding
//  - fetch beat record held in the instruction buffer
//  - use_rs1 / use_rs2: which opcodes actually read rs1 / rs2
package xrv_issue_ctrl_pkg;

  localparam logic [6:0] OP_JALR     = 7'b1100111;
  localparam logic [6:0] OP_BRANCH   = 7'b1100011;
  localparam logic [6:0] OP_LOAD     = 7'b0000011;
  localparam logic [6:0] OP_STORE    = 7'b0100011;
  localparam logic [6:0] OP_IMM      = 7'b0010011;
  localparam logic [6:0] OP_REG      = 7'b0110011;
  // M-extension shares the OP major opcode; funct7 tells them apart, which
  // does not matter for operand usage.
  localparam logic [6:0] OP_MULT_DIV = 7'b0110011;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    BUBBLE = 2'd1,
    KILL   = 2'd2
  } issue_st_e;

  typedef struct packed {
    logic        compressed;
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_beat_t;

  function automatic logic use_rs1(input logic [6:0] op);
    return op inside {OP_JALR, OP_BRANCH, OP_LOAD, OP_STORE, OP_IMM, OP_REG, OP_MULT_DIV};
  endfunction

  function automatic logic use_rs2(input logic [6:0] op);
    return op inside {OP_BRANCH, OP_STORE, OP_REG, OP_MULT_DIV};
  endfunction

endpackage

// File: rtl/xrv_inst_fifo.sv
// Circular instruction buffer with wrap-bit pointers.
// Ports:
//  clk, rstb   clock, synchronous active-low reset (pointers only)
//  clr_i       drop every entry (pointers return to 0)
//  trunc_i     keep only the head: write ptr := read ptr + 1 (used with pop_i,
//              so the buffer ends up empty after the head leaves)
//  push_i      write wdata_i at the write pointer
//  pop_i       advance the read pointer
//  rdata_o     head entry
//  full_o      all DEPTH entries occupied
//  empty_o     no entries
module xrv_inst_fifo
  import xrv_issue_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic        clk,
  input  logic        rstb,
  input  logic        clr_i,
  input  logic        trunc_i,
  input  logic        push_i,
  input  fetch_beat_t wdata_i,
  input  logic        pop_i,
  output fetch_beat_t rdata_o,
  output logic        full_o,
  output logic        empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  logic [AW:0] wr_q, wr_d;
  logic [AW:0] rd_q, rd_d;
  fetch_beat_t mem_q [DEPTH];

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (clr_i) begin
      wr_d = '0;
      rd_d = '0;
    end else begin
      if (pop_i) rd_d = rd_q + PTR_ONE;
      if (trunc_i)     wr_d = rd_q + PTR_ONE;
      else if (push_i) wr_d = wr_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstb) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  // Storage carries no reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (push_i && !clr_i && !trunc_i) mem_q[wr_q[AW-1:0]] <= wdata_i;
  end

  assign full_o  = (wr_q[AW-1:0] == rd_q[AW-1:0]) && (wr_q[AW] != rd_q[AW]);
  assign empty_o = (wr_q == rd_q);
  assign rdata_o = mem_q[rd_q[AW-1:0]];

endmodule

// File: rtl/xrv_issue_ctrl.sv
// Issue controller between fetch and the decoder.
// Buffers fetch beats and presents the head to the decoder when it is safe:
// inserts load-use bubbles against the instruction in EX, holds on EX stall,
// discards wrong-path work on decoder JAL redirect and on EX flush.
// Ports:
//  clk, rstb                      clock, synchronous active-low reset
//  flush                          EX redirect; kills buffered and incoming work
//  if_inst/if_pc/if_compressed    fetch beat payload
//  if_valid / if_ready            fetch handshake
//  id_inst/id_pc/id_compressed    head payload to the decoder (0 when empty)
//  id_valid                       issue strobe
//  id_jmp                         decoder JAL redirect, same cycle as id_valid
//  ex_valid/ex_op_load/ex_dest    EX instruction info for hazard detection
//  ex_stall                       EX cannot take a new instruction
//  bubble                         load-use bubble inserted this cycle
module xrv_issue_ctrl
  import xrv_issue_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH    = 2,
  parameter int unsigned KILL_CYC = 1
) (
  input  logic        clk,
  input  logic        rstb,
  input  logic        flush,
  input  logic [31:0] if_inst,
  input  logic [31:0] if_pc,
  input  logic        if_compressed,
  input  logic        if_valid,
  output logic        if_ready,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc,
  output logic        id_compressed,
  output logic        id_valid,
  input  logic        id_jmp,
  input  logic        ex_valid,
  input  logic        ex_op_load,
  input  logic [4:0]  ex_dest,
  input  logic        ex_stall,
  output logic        bubble
);

  localparam int unsigned CNT_W = (KILL_CYC > 1) ? $clog2(KILL_CYC) : 1;
  localparam logic [CNT_W-1:0] KILL_LOAD = CNT_W'(KILL_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  issue_st_e        state_q;
  logic [CNT_W-1:0] cnt_q;

  fetch_beat_t wbeat;
  fetch_beat_t head;
  logic        full;
  logic        empty;
  logic        push;
  logic        trunc;
  logic [6:0]  head_op;
  logic        haz;
  logic        can_issue;

  assign wbeat = '{compressed: if_compressed, pc: if_pc, inst: if_inst};

  // Ready is also held low while reset is asserted so nothing is captured.
  assign if_ready = rstb && !full && (state_q != KILL);
  assign push     = if_valid && if_ready && !flush && !id_jmp;

  assign head_op = head.inst[6:0];
  assign haz = ex_valid && ex_op_load && (ex_dest != 5'd0) &&
               ((use_rs1(head_op) && (ex_dest == head.inst[19:15])) ||
                (use_rs2(head_op) && (ex_dest == head.inst[24:20])));

  assign can_issue = !empty && (state_q == RUN) && !ex_stall && !flush;
  assign id_valid  = can_issue && !haz;
  assign bubble    = can_issue && haz;

  // A JAL redirect keeps only the issuing head; younger entries are wrong-path.
  assign trunc = id_valid && id_jmp;

  assign id_inst       = empty ? 32'd0 : head.inst;
  assign id_pc         = empty ? 32'd0 : head.pc;
  assign id_compressed = empty ? 1'b0  : head.compressed;

  xrv_inst_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rstb    (rstb),
    .clr_i   (flush),
    .trunc_i (trunc),
    .push_i  (push),
    .wdata_i (wbeat),
    .pop_i   (id_valid),
    .rdata_o (head),
    .full_o  (full),
    .empty_o (empty)
  );

  // BUBBLE lasts one cycle: by then EX has consumed the load (ex_valid drops),
  // so the hazard has cleared. KILL covers the fetch in-flight window.
  always_ff @(posedge clk) begin
    if (!rstb) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        RUN: begin
          if (flush) begin
            state_q <= KILL;
            cnt_q   <= KILL_LOAD;
          end else if (bubble) begin
            state_q <= BUBBLE;
          end
        end
        BUBBLE: begin
          if (flush) begin
            state_q <= KILL;
            cnt_q   <= KILL_LOAD;
          end else begin
            state_q <= RUN;
          end
        end
        KILL: begin
          if (flush)              cnt_q   <= KILL_LOAD;
          else if (cnt_q == '0)   state_q <= RUN;
          else                    cnt_q   <= cnt_q - CNT_ONE;
        end
        default: state_q <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_xrv_issue_ctrl.sv
module tb_xrv_issue_ctrl;

  logic        clk = 1'b0;
  logic        rstb;
  logic        flush;
  logic [31:0] if_inst;
  logic [31:0] if_pc;
  logic        if_compressed;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] id_inst;
  logic [31:0] id_pc;
  logic        id_compressed;
  logic        id_valid;
  logic        id_jmp;
  logic        ex_valid;
  logic        ex_op_load;
  logic [4:0]  ex_dest;
  logic        ex_stall;
  logic        bubble;

  int n_chk = 0;
  int n_err = 0;

  // Expected issue stream: {compressed, pc, inst}
  logic [64:0] exp_q [$];

  localparam logic [31:0] ADD_X6_X5_X7 = 32'h00728333;
  localparam logic [31:0] ADD_X6_X0_X7 = 32'h00700333;
  localparam logic [31:0] SW_X5_0_X1   = 32'h0050A023;
  localparam logic [31:0] LUI_X5_RS1F5 = 32'h000282B7;
  localparam logic [31:0] JAL_X0       = 32'h0000006F;

  xrv_issue_ctrl #(
    .DEPTH    (2),
    .KILL_CYC (2)
  ) dut (
    .clk           (clk),
    .rstb          (rstb),
    .flush         (flush),
    .if_inst       (if_inst),
    .if_pc         (if_pc),
    .if_compressed (if_compressed),
    .if_valid      (if_valid),
    .if_ready      (if_ready),
    .id_inst       (id_inst),
    .id_pc         (id_pc),
    .id_compressed (id_compressed),
    .id_valid      (id_valid),
    .id_jmp        (id_jmp),
    .ex_valid      (ex_valid),
    .ex_op_load    (ex_op_load),
    .ex_dest       (ex_dest),
    .ex_stall      (ex_stall),
    .bubble        (bubble)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [64:0] act, input logic [64:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mk_inst(input logic [31:0] pc);
    return {pc[11:0], 20'h00013};
  endfunction

  task automatic drive_beat(input logic [31:0] pc, input logic [31:0] inst, input bit expect_issue);
    if_valid      = 1'b1;
    if_pc         = pc;
    if_inst       = inst;
    if_compressed = pc[2];
    if (expect_issue) exp_q.push_back({pc[2], pc, inst});
  endtask

  // Scoreboard: every issue strobe must match the oldest expected beat.
  always @(negedge clk) begin
    if (rstb === 1'b1 && id_valid === 1'b1) begin
      if (exp_q.size() == 0) check_eq("sb_underflow", exp_q.size(), 1);
      else check_eq("issue", {id_compressed, id_pc, id_inst}, exp_q.pop_front());
    end
  end

  task automatic haz_case(input logic [31:0] pc, input logic [31:0] inst,
                          input logic [4:0] dest, input logic exp_bub);
    ex_valid   = 1'b1;
    ex_op_load = 1'b1;
    ex_dest    = dest;
    drive_beat(pc, inst, 1'b1);
    cyc();
    if_valid = 1'b0;
    @(negedge clk);
    check_eq("haz_bubble", bubble, exp_bub);
    check_eq("haz_issue", id_valid, !exp_bub);
    cyc();
    if (exp_bub) begin
      ex_valid = 1'b0;
      @(negedge clk);
      check_eq("bub_state_valid", id_valid, 0);
      check_eq("bub_state_bubble", bubble, 0);
      cyc();
      @(negedge clk);
      check_eq("post_bubble_issue", id_valid, 1);
      cyc();
    end
    ex_valid   = 1'b0;
    ex_op_load = 1'b0;
    ex_dest    = 5'd0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rstb = 1'b0; flush = 1'b0; id_jmp = 1'b0;
    ex_valid = 1'b0; ex_op_load = 1'b0; ex_dest = 5'd0; ex_stall = 1'b0;
    if_valid = 1'b1; if_pc = 32'h0; if_inst = mk_inst(32'h0); if_compressed = 1'b0;

    // Reset held two cycles with a beat offered
    cyc();
    @(negedge clk);
    check_eq("rst_id_valid", id_valid, 0);
    check_eq("rst_if_ready", if_ready, 0);
    check_eq("rst_bubble", bubble, 0);
    check_eq("rst_id_pc", id_pc, 0);
    check_eq("rst_id_inst", id_inst, 0);
    cyc();
    rstb = 1'b1;

    // Streaming 8 beats back-to-back
    for (int i = 0; i < 8; i++) begin
      drive_beat(32'(4 * i), mk_inst(32'(4 * i)), 1'b1);
      @(negedge clk);
      check_eq("stream_ready", if_ready, 1);
      check_eq("stream_valid", id_valid, (i > 0) ? 1 : 0);
      cyc();
    end
    if_valid = 1'b0;
    @(negedge clk);
    check_eq("stream_last", id_valid, 1);
    cyc();
    @(negedge clk);
    check_eq("stream_drained", id_valid, 0);
    cyc();

    // Load-use hazards
    haz_case(32'h40, ADD_X6_X5_X7, 5'd5, 1'b1);
    haz_case(32'h44, ADD_X6_X5_X7, 5'd7, 1'b1);
    haz_case(32'h48, SW_X5_0_X1,   5'd5, 1'b1);
    haz_case(32'h4C, ADD_X6_X0_X7, 5'd0, 1'b0);
    haz_case(32'h50, LUI_X5_RS1F5, 5'd5, 1'b0);

    // EX stall fills the buffer; release drains in order
    ex_stall = 1'b1;
    for (int c = 0; c < 5; c++) begin
      int idx;
      idx = (c < 2) ? c : 2;
      drive_beat(32'h80 + 32'(4 * idx), mk_inst(32'h80 + 32'(4 * idx)), c < 2);
      @(negedge clk);
      check_eq("stall_ready", if_ready, (c < 2) ? 1 : 0);
      check_eq("stall_no_issue", id_valid, 0);
      cyc();
    end
    ex_stall = 1'b0;
    @(negedge clk);
    check_eq("release_full_ready", if_ready, 0);
    check_eq("release_issue", id_valid, 1);
    cyc();
    exp_q.push_back({1'b0, 32'h88, mk_inst(32'h88)});
    @(negedge clk);
    check_eq("release_ready", if_ready, 1);
    cyc();
    if_valid = 1'b0;
    @(negedge clk);
    check_eq("release_last", id_valid, 1);
    cyc();
    @(negedge clk);
    check_eq("release_drained", id_valid, 0);
    cyc();

    // JAL redirect with a younger entry buffered and a beat arriving
    ex_stall = 1'b1;
    drive_beat(32'h100, JAL_X0, 1'b1);
    cyc();
    drive_beat(32'h104, mk_inst(32'h104), 1'b0);
    cyc();
    ex_stall = 1'b0;
    id_jmp   = 1'b1;
    drive_beat(32'h108, mk_inst(32'h108), 1'b0);
    @(negedge clk);
    check_eq("jal_issue", id_valid, 1);
    cyc();
    id_jmp = 1'b0;
    drive_beat(32'h200, mk_inst(32'h200), 1'b1);
    @(negedge clk);
    check_eq("jal_discard", id_valid, 0);
    cyc();
    if_valid = 1'b0;
    @(negedge clk);
    check_eq("jal_target", id_valid, 1);
    cyc();

    // JAL redirect drops a beat accepted-looking in the same cycle
    drive_beat(32'h300, JAL_X0, 1'b1);
    cyc();
    id_jmp = 1'b1;
    drive_beat(32'h304, mk_inst(32'h304), 1'b0);
    @(negedge clk);
    check_eq("jal2_issue", id_valid, 1);
    cyc();
    id_jmp   = 1'b0;
    if_valid = 1'b0;
    @(negedge clk);
    check_eq("jal2_drop_incoming", id_valid, 0);
    cyc();
    drive_beat(32'h400, mk_inst(32'h400), 1'b1);
    cyc();
    if_valid = 1'b0;
    @(negedge clk);
    check_eq("jal2_target", id_valid, 1);
    cyc();

    // Flush with two entries, KILL lasts two cycles
    ex_stall = 1'b1;
    drive_beat(32'h500, mk_inst(32'h500), 1'b0);
    cyc();
    drive_beat(32'h504, mk_inst(32'h504), 1'b0);
    cyc();
    ex_stall = 1'b0;
    flush    = 1'b1;
    drive_beat(32'h508, mk_inst(32'h508), 1'b0);
    @(negedge clk);
    check_eq("flush_no_issue", id_valid, 0);
    cyc();
    flush = 1'b0;
    drive_beat(32'h600, mk_inst(32'h600), 1'b0);
    @(negedge clk);
    check_eq("kill1_ready", if_ready, 0);
    check_eq("kill1_valid", id_valid, 0);
    cyc();
    drive_beat(32'h604, mk_inst(32'h604), 1'b0);
    @(negedge clk);
    check_eq("kill2_ready", if_ready, 0);
    cyc();
    drive_beat(32'h608, mk_inst(32'h608), 1'b1);
    @(negedge clk);
    check_eq("kill_exit_ready", if_ready, 1);
    cyc();
    if_valid = 1'b0;
    @(negedge clk);
    check_eq("kill_exit_issue", id_valid, 1);
    cyc();

    // Flush during BUBBLE goes to KILL
    ex_valid = 1'b1; ex_op_load = 1'b1; ex_dest = 5'd5;
    drive_beat(32'h700, ADD_X6_X5_X7, 1'b0);
    cyc();
    if_valid = 1'b0;
    @(negedge clk);
    check_eq("bf_bubble", bubble, 1);
    cyc();
    ex_valid = 1'b0; ex_op_load = 1'b0; ex_dest = 5'd0;
    flush = 1'b1;
    @(negedge clk);
    check_eq("bf_no_issue", id_valid, 0);
    cyc();
    flush = 1'b0;
    @(negedge clk);
    check_eq("bf_kill_ready", if_ready, 0);
    check_eq("bf_kill_valid", id_valid, 0);
    cyc();
    cyc();
    drive_beat(32'h800, mk_inst(32'h800), 1'b1);
    @(negedge clk);
    check_eq("bf_run_ready", if_ready, 1);
    cyc();
    if_valid = 1'b0;
    @(negedge clk);
    check_eq("bf_run_issue", id_valid, 1);
    cyc();

    // Reset mid-operation discards buffered work
    ex_stall = 1'b1;
    drive_beat(32'h900, mk_inst(32'h900), 1'b0);
    cyc();
    if_valid = 1'b0;
    rstb     = 1'b0;
    @(negedge clk);
    check_eq("mid_rst_ready", if_ready, 0);
    cyc();
    rstb     = 1'b1;
    ex_stall = 1'b0;
    @(negedge clk);
    check_eq("mid_rst_discard", id_valid, 0);
    check_eq("mid_rst_ready_after", if_ready, 1);
    cyc();

    check_eq("sb_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
